id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core.
- Captures operands from the register file read ports (read_data1/read_data2) and the decoded control for the instruction in ID, and presents them to EX one cycle later.
- Bypasses same-cycle write-back data around the register file.
- Detects load-use hazards, inserting a bubble and stalling IF/ID.
- Honours downstream hold and branch flush.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_ADDR_W, 5, register index width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_ADDR_W  source reg 1 index (drives register file read_reg1)
- id_rt  in  REG_ADDR_W  source reg 2 index (read_reg2)
- id_uses_rt  in  1  instruction reads rt as a source
- id_dest  in  REG_ADDR_W  destination register index (rd or rt, already muxed)
- id_read_data1  in  DATA_W  register file read_data1
- id_read_data2  in  DATA_W  register file read_data2
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  in  1 each  decoded control
- id_alu_op  in  4  ALU operation
- wb_reg_write  in  1  WB writes the register file this cycle
- wb_write_reg  in  REG_ADDR_W  WB destination
- wb_write_data  in  DATA_W  WB data
- ex_hold  in  1  EX cannot accept (multicycle op); freeze
- flush  in  1  branch/jump resolved taken; squash ID/EX
- ex_valid  out  1  EX register holds a real instruction
- ex_rs, ex_rt, ex_dest  out  REG_ADDR_W  registered indices
- ex_op_a, ex_op_b, ex_imm  out  DATA_W  registered operands
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each  registered control
- ex_alu_op  out  4  registered ALU op
- stall_out  out  1  freeze PC and IF/ID this cycle
- bubble_count  out  CNT_W  saturating count of load-use bubbles inserted

Behaviour:
- Reset: rst_n low asynchronously clears every registered output and bubble_count to 0. ex_valid=0 means a bubble. stall_out is 0 while in reset.
- Load-use detection is combinational:
  - load_use = id_valid & ex_valid & ex_mem_read & (ex_dest!=0) & ((ex_dest==id_rs) | (id_uses_rt & ex_dest==id_rt))
  - stall_out = (load_use | ex_hold) & ~flush
- Operand select, with write-first bypass because the register file reads combinationally:
  - op_a_next = 0 if id_rs==0.
  - Otherwise op_a_next = wb_write_data if wb_reg_write & wb_write_reg==id_rs.
  - Otherwise op_a_next = id_read_data1.
  - op_b_next follows the same rules using id_rt and id_read_data2.
  - Bypass is independent of id_uses_rt.
- Update at posedge clk, in priority order:
  1. flush: load a bubble (ex_valid=0, all control outputs 0, indices/operands 0). Overrides ex_hold.
  2. ex_hold: all ex_* outputs hold their values.
  3. load_use: load a bubble. bubble_count increments and saturates at all-ones.
  4. Otherwise: load the ID contents. ex_valid=id_valid. When id_valid=0, all control outputs load 0.
- Latency: one cycle from ID to EX.
- A load-use stall lasts exactly one cycle: after the bubble, ex_mem_read=0 and load_use deasserts.
- Bubbles never carry reg_write or mem_write, so a bubble produces no architectural effect.
- The held EX contents are not re-bypassed during ex_hold. Forwarding for EX is owned by the forwarding unit.
- The ID instruction re-reads the register file after any stall, so WB writes during a stall are observed.
- Register 0: a dest of 0 never triggers load_use, and a source of 0 always reads 0.
- Reset asserted mid-stall: all state clears and stall_out drops immediately.

Decomposition:
- Shared package mips_pkg holds:
  - ALU op encodings (4-bit localparams)
  - REG_ZERO constant
  - DATA_W/REG_ADDR_W defaults
- One sub-module, hazard_detect, holds the combinational load_use/stall_out logic. It is reused by the future forwarding unit.
- Operand bypass stays inline.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release → all ex_* = 0, bubble_count = 0, stall_out = 0.
- Normal flow: ID add rs=3 (data 0x11), rt=4 (data 0x22), dest=5, reg_write=1 → next cycle ex_op_a=0x11, ex_op_b=0x22, ex_dest=5, ex_valid=1.
- WB bypass: ID rs=7 with id_read_data1=0xAAAA, while wb_reg_write=1, wb_write_reg=7, wb_write_data=0x1234 → ex_op_a=0x1234. Repeat with rs=0 and wb_write_reg=0 → ex_op_a=0.
- Load-use: EX holds lw dest=8, ID sub rs=8 → stall_out=1 for one cycle, ex_valid=0 next, bubble_count=1. The following cycle ex_op_a takes the fresh register value.
- Flush vs hold: ex_hold=1 and flush=1 together → stall_out=0, next ex_valid=0. ex_hold alone for 3 cycles → ex_* unchanged and stall_out=1 throughout.
- Saturation: force 2^CNT_W+2 load-use events → bubble_count stays at 0xFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types: ALU op encodings, register-zero index and default widths.
// Pure declarations, no logic.
package mips_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 16;

    localparam int REG_ZERO = 0;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: ID-side operands/control, WB bypass, EX-side registered outputs.
// slave = the ID/EX stage, master = whoever drives ID/WB and consumes EX.
interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_dest;
    logic [DATA_W-1:0]     id_read_data1;
    logic [DATA_W-1:0]     id_read_data2;
    logic [DATA_W-1:0]     id_imm;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_mem_to_reg;
    logic                  id_alu_src;
    logic [3:0]            id_alu_op;

    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_write_reg;
    logic [DATA_W-1:0]     wb_write_data;

    logic                  ex_hold;
    logic                  flush;

    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic [DATA_W-1:0]     ex_op_a;
    logic [DATA_W-1:0]     ex_op_b;
    logic [DATA_W-1:0]     ex_imm;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_mem_to_reg;
    logic                  ex_alu_src;
    logic [3:0]            ex_alu_op;
    logic                  stall_out;
    logic [CNT_W-1:0]      bubble_count;

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_read_data1, id_read_data2,
               id_imm, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
               id_alu_op, wb_reg_write, wb_write_reg, wb_write_data, ex_hold, flush,
        output ex_valid, ex_rs, ex_rt, ex_dest, ex_op_a, ex_op_b, ex_imm, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
               stall_out, bubble_count
    );

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_read_data1, id_read_data2,
               id_imm, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
               id_alu_op, wb_reg_write, wb_write_reg, wb_write_data, ex_hold, flush,
        input  ex_valid, ex_rs, ex_rt, ex_dest, ex_op_a, ex_op_b, ex_imm, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
               stall_out, bubble_count
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: EX load whose dest is a source of the ID instruction.
// Latency: combinational. Backpressure: stall_o covers load-use and downstream hold; flush cancels it.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_dest_i,
    input  logic                  ex_hold_i,
    input  logic                  flush_i,
    output logic                  load_use_o,
    output logic                  stall_o
);
    logic dest_live;
    logic src_match;

    // A load into $zero has no consumer worth waiting for.
    assign dest_live  = (ex_dest_i != REG_ADDR_W'(REG_ZERO));
    assign src_match  = (ex_dest_i == id_rs_i) | (id_uses_rt_i & (ex_dest_i == id_rt_i));
    assign load_use_o = id_valid_i & ex_valid_i & ex_mem_read_i & dest_live & src_match;
    assign stall_o    = (load_use_o | ex_hold_i) & ~flush_i;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-first WB bypass, load-use bubble insertion and flush/hold.
// Latency: 1 cycle ID->EX. Backpressure: ex_hold freezes EX and raises stall_out; flush wins over hold.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    logic load_use;
    logic stall_raw;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .id_valid_i    (bus.id_valid),
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .id_uses_rt_i  (bus.id_uses_rt),
        .ex_valid_i    (bus.ex_valid),
        .ex_mem_read_i (bus.ex_mem_read),
        .ex_dest_i     (bus.ex_dest),
        .ex_hold_i     (bus.ex_hold),
        .flush_i       (bus.flush),
        .load_use_o    (load_use),
        .stall_o       (stall_raw)
    );

    // ex_hold is external, so gate with reset to keep IF/ID free while held in reset.
    assign bus.stall_out = stall_raw & rst_n;

    logic [DATA_W-1:0] op_a_next;
    logic [DATA_W-1:0] op_b_next;

    // Register file reads combinationally, so a same-cycle WB write must be forwarded here.
    always_comb begin
        op_a_next = bus.id_read_data1;
        if (bus.id_rs == REG_ADDR_W'(REG_ZERO)) begin
            op_a_next = '0;
        end else if (bus.wb_reg_write && (bus.wb_write_reg == bus.id_rs)) begin
            op_a_next = bus.wb_write_data;
        end
    end

    always_comb begin
        op_b_next = bus.id_read_data2;
        if (bus.id_rt == REG_ADDR_W'(REG_ZERO)) begin
            op_b_next = '0;
        end else if (bus.wb_reg_write && (bus.wb_write_reg == bus.id_rt)) begin
            op_b_next = bus.wb_write_data;
        end
    end

    ctrl_t id_ctrl;
    assign id_ctrl = '{reg_write:  bus.id_reg_write,
                       mem_read:   bus.id_mem_read,
                       mem_write:  bus.id_mem_write,
                       mem_to_reg: bus.id_mem_to_reg,
                       alu_src:    bus.id_alu_src,
                       alu_op:     bus.id_alu_op};

    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    logic [DATA_W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        valid_d = valid_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        dest_d  = dest_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (bus.flush || (!bus.ex_hold && load_use)) begin
            valid_d = 1'b0;
            rs_d    = '0;
            rt_d    = '0;
            dest_d  = '0;
            op_a_d  = '0;
            op_b_d  = '0;
            imm_d   = '0;
            ctrl_d  = CTRL_NOP;
            if (!bus.flush && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!bus.ex_hold) begin
            valid_d = bus.id_valid;
            rs_d    = bus.id_rs;
            rt_d    = bus.id_rt;
            dest_d  = bus.id_dest;
            op_a_d  = op_a_next;
            op_b_d  = op_b_next;
            imm_d   = bus.id_imm;
            ctrl_d  = bus.id_valid ? id_ctrl : CTRL_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            dest_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            imm_q   <= '0;
            ctrl_q  <= CTRL_NOP;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            dest_q  <= dest_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_valid      = valid_q;
    assign bus.ex_rs         = rs_q;
    assign bus.ex_rt         = rt_q;
    assign bus.ex_dest       = dest_q;
    assign bus.ex_op_a       = op_a_q;
    assign bus.ex_op_b       = op_b_q;
    assign bus.ex_imm        = imm_q;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_alu_src    = ctrl_q.alu_src;
    assign bus.ex_alu_op     = ctrl_q.alu_op;
    assign bus.bubble_count  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model pushes expected EX state per clock, tasks pop and compare.
// Bubble counter is narrowed so saturation is reachable in a short run.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 6;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] dest;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          m2r;
        logic          as;
        logic [3:0]    op;
        logic [CW-1:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t m = '0;
    obs_t q[$];

    function automatic obs_t sample();
        obs_t o;
        o.valid = bus.ex_valid;      o.rs  = bus.ex_rs;         o.rt  = bus.ex_rt;
        o.dest  = bus.ex_dest;       o.a   = bus.ex_op_a;       o.b   = bus.ex_op_b;
        o.imm   = bus.ex_imm;        o.rw  = bus.ex_reg_write;  o.mr  = bus.ex_mem_read;
        o.mw    = bus.ex_mem_write;  o.m2r = bus.ex_mem_to_reg; o.as  = bus.ex_alu_src;
        o.op    = bus.ex_alu_op;     o.cnt = bus.bubble_count;
        return o;
    endfunction

    function automatic logic [DW-1:0] opsel(logic [AW-1:0] r, logic [DW-1:0] rd);
        if (r == '0) return '0;
        if (bus.wb_reg_write && bus.wb_write_reg == r) return bus.wb_write_data;
        return rd;
    endfunction

    function automatic obs_t model_next(obs_t c);
        obs_t n;
        bit   lu;
        lu = bus.id_valid && c.valid && c.mr && (c.dest != '0) &&
             ((c.dest == bus.id_rs) || (bus.id_uses_rt && c.dest == bus.id_rt));
        n = c;
        if (bus.flush) begin
            n = '0;
            n.cnt = c.cnt;
        end else if (bus.ex_hold) begin
            n = c;
        end else if (lu) begin
            n = '0;
            n.cnt = (c.cnt == {CW{1'b1}}) ? c.cnt : c.cnt + 1'b1;
        end else begin
            n.valid = bus.id_valid;
            n.rs    = bus.id_rs;
            n.rt    = bus.id_rt;
            n.dest  = bus.id_dest;
            n.a     = opsel(bus.id_rs, bus.id_read_data1);
            n.b     = opsel(bus.id_rt, bus.id_read_data2);
            n.imm   = bus.id_imm;
            n.rw    = bus.id_valid & bus.id_reg_write;
            n.mr    = bus.id_valid & bus.id_mem_read;
            n.mw    = bus.id_valid & bus.id_mem_write;
            n.m2r   = bus.id_valid & bus.id_mem_to_reg;
            n.as    = bus.id_valid & bus.id_alu_src;
            n.op    = bus.id_valid ? bus.id_alu_op : 4'd0;
        end
        return n;
    endfunction

    task automatic tick();
        obs_t n;
        n = model_next(m);
        q.push_back(n);
        m = n;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic urt, input logic [AW-1:0] dest,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                          input logic rw, input logic mr, input logic mw, input logic m2r,
                          input logic as, input logic [3:0] op);
        bus.id_valid = v;       bus.id_rs = rs;          bus.id_rt = rt;
        bus.id_uses_rt = urt;   bus.id_dest = dest;      bus.id_read_data1 = d1;
        bus.id_read_data2 = d2; bus.id_imm = imm;        bus.id_reg_write = rw;
        bus.id_mem_read = mr;   bus.id_mem_write = mw;   bus.id_mem_to_reg = m2r;
        bus.id_alu_src = as;    bus.id_alu_op = op;
    endtask

    task automatic set_wb(input logic we, input logic [AW-1:0] r, input logic [DW-1:0] d);
        bus.wb_reg_write = we; bus.wb_write_reg = r; bus.wb_write_data = d;
    endtask

    task automatic set_idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
        set_wb(0, 0, 0);
        bus.ex_hold = 1'b0;
        bus.flush   = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                   $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 4'($urandom));
            set_wb(1'($urandom), 5'($urandom), $urandom);
            bus.ex_hold = 1'b1;
            bus.flush   = 1'b0;
            @(negedge clk);
            o = sample();
            checks++;
            if (o !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", o); end
            checks++;
            if (bus.stall_out !== 1'b0) begin
                errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_out);
            end
        end
        set_idle();
        rst_n = 1'b1;
        m = '0;
        #1;
        o = sample();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_release: got %h expected 0", o); end
        checks++;
        if (bus.stall_out !== 1'b0) begin
            errors++; $display("FAIL reset_release_stall: got %b expected 0", bus.stall_out);
        end
    endtask

    task automatic pop_cmp(input string name);
        obs_t e, o;
        e = q.pop_front();
        o = sample();
        checks++;
        if (o !== e) begin errors++; $display("FAIL %s: got %h expected %h", name, o, e); end
    endtask

    task automatic test_normal();
        set_id(1, 3, 4, 1, 5, 32'h11, 32'h22, 32'h7, 1, 0, 0, 0, 0, ALU_ADD);
        #1;
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL normal_stall: got %b expected 0", bus.stall_out); end
        tick();
        pop_cmp("normal_sb");
        checks++;
        if (bus.ex_op_a !== 32'h11 || bus.ex_op_b !== 32'h22 || bus.ex_dest !== 5'd5 || bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL normal_direct: got a=%h b=%h dest=%0d v=%b expected a=11 b=22 dest=5 v=1",
                     bus.ex_op_a, bus.ex_op_b, bus.ex_dest, bus.ex_valid);
        end
        set_id(0, 6, 7, 1, 9, 32'h33, 32'h44, 32'h1, 1, 1, 1, 1, 1, ALU_SUB);
        tick();
        pop_cmp("invalid_id_sb");
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_write !== 1'b0) begin
            errors++; $display("FAIL invalid_id_ctrl: got v=%b rw=%b mw=%b expected 0 0 0",
                               bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write);
        end
    endtask

    task automatic test_bypass();
        set_id(1, 7, 2, 1, 3, 32'hAAAA, 32'h5, 0, 1, 0, 0, 0, 0, ALU_OR);
        set_wb(1, 7, 32'h1234);
        tick();
        pop_cmp("bypass_sb");
        checks++;
        if (bus.ex_op_a !== 32'h1234) begin errors++; $display("FAIL bypass_rs: got %h expected 1234", bus.ex_op_a); end
        set_id(1, 0, 2, 1, 3, 32'hAAAA, 32'h5, 0, 1, 0, 0, 0, 0, ALU_OR);
        set_wb(1, 0, 32'h1234);
        tick();
        pop_cmp("bypass_zero_sb");
        checks++;
        if (bus.ex_op_a !== 32'h0) begin errors++; $display("FAIL bypass_zero: got %h expected 0", bus.ex_op_a); end
        set_id(1, 1, 9, 0, 3, 32'h1, 32'h55, 0, 1, 0, 0, 0, 1, ALU_ADD);
        set_wb(1, 9, 32'hBEEF);
        tick();
        pop_cmp("bypass_rt_sb");
        checks++;
        if (bus.ex_op_b !== 32'hBEEF) begin errors++; $display("FAIL bypass_rt: got %h expected beef", bus.ex_op_b); end
        set_wb(0, 0, 0);
    endtask

    task automatic test_load_use();
        set_id(1, 1, 8, 0, 8, 32'h100, 32'h0, 32'h4, 1, 1, 0, 1, 1, ALU_ADD);
        tick();
        pop_cmp("lw_sb");
        set_id(1, 8, 2, 1, 10, 32'hDEAD, 32'h3, 0, 1, 0, 0, 0, 0, ALU_SUB);
        #1;
        checks++;
        if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", bus.stall_out); end
        tick();
        pop_cmp("lu_bubble_sb");
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.bubble_count !== CW'(1) || bus.ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL lu_bubble: got v=%b cnt=%0d rw=%b expected v=0 cnt=1 rw=0",
                               bus.ex_valid, bus.bubble_count, bus.ex_reg_write);
        end
        bus.id_read_data1 = 32'hF00D;
        #1;
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", bus.stall_out); end
        tick();
        pop_cmp("lu_fresh_sb");
        checks++;
        if (bus.ex_op_a !== 32'hF00D) begin errors++; $display("FAIL lu_fresh: got %h expected f00d", bus.ex_op_a); end
        set_id(1, 1, 0, 0, 0, 32'h1, 32'h0, 0, 1, 1, 0, 1, 1, ALU_ADD);
        tick();
        pop_cmp("lw_r0_sb");
        set_id(1, 0, 0, 1, 4, 32'h0, 32'h0, 0, 1, 0, 0, 0, 0, ALU_ADD);
        #1;
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL lu_r0: got %b expected 0", bus.stall_out); end
        tick();
        pop_cmp("r0_consumer_sb");
        set_id(1, 1, 0, 0, 12, 32'h1, 32'h0, 0, 1, 1, 0, 1, 1, ALU_ADD);
        tick();
        pop_cmp("lw12_sb");
        set_id(1, 1, 12, 0, 4, 32'h1, 32'h9, 32'h8, 1, 0, 0, 0, 1, ALU_ADD);
        #1;
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL lu_rt_unused: got %b expected 0", bus.stall_out); end
        tick();
        pop_cmp("rt_unused_sb");
    endtask

    task automatic test_flush_hold();
        obs_t held;
        set_id(1, 2, 3, 1, 4, 32'h21, 32'h31, 0, 1, 0, 0, 0, 0, ALU_AND);
        tick();
        pop_cmp("pre_flush_sb");
        set_id(1, 5, 6, 1, 7, 32'h51, 32'h61, 0, 1, 0, 0, 0, 0, ALU_XOR);
        bus.ex_hold = 1'b1;
        bus.flush   = 1'b1;
        #1;
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL flush_hold_stall: got %b expected 0", bus.stall_out); end
        tick();
        pop_cmp("flush_sb");
        checks++;
        if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.ex_valid); end
        bus.ex_hold = 1'b0;
        bus.flush   = 1'b0;
        tick();
        pop_cmp("post_flush_sb");
        held = sample();
        bus.ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 5'(i + 10), 5'(i + 20), 1, 5'(i + 1), $urandom, $urandom, $urandom, 1, 1, 1, 0, 1, ALU_SLT);
            set_wb(1, 5'(i + 10), $urandom);
            #1;
            checks++;
            if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL hold_stall: got %b expected 1", bus.stall_out); end
            tick();
            pop_cmp("hold_sb");
            checks++;
            if (sample() !== held) begin errors++; $display("FAIL hold_frozen: got %h expected %h", sample(), held); end
        end
        bus.ex_hold = 1'b0;
        set_wb(0, 0, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            set_id(1, 1, 0, 0, 9, 32'h1, 32'h0, 0, 1, 1, 0, 1, 1, ALU_ADD);
            tick();
            pop_cmp("sat_lw_sb");
            set_id(1, 9, 2, 1, 3, 32'h2, 32'h3, 0, 1, 0, 0, 0, 0, ALU_SUB);
            tick();
            pop_cmp("sat_bubble_sb");
        end
        checks++;
        if (bus.bubble_count !== {CW{1'b1}}) begin
            errors++; $display("FAIL saturation: got %h expected %h", bus.bubble_count, {CW{1'b1}});
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t o;
        set_id(1, 1, 0, 0, 11, 32'h1, 32'h0, 0, 1, 1, 0, 1, 1, ALU_ADD);
        tick();
        pop_cmp("mid_lw_sb");
        set_id(1, 11, 2, 1, 3, 32'h2, 32'h3, 0, 1, 0, 0, 0, 0, ALU_SUB);
        #1;
        checks++;
        if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %b expected 1", bus.stall_out); end
        #1;
        rst_n = 1'b0;
        m = '0;
        #1;
        checks++;
        if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL mid_stall_drop: got %b expected 0", bus.stall_out); end
        o = sample();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL mid_reset_state: got %h expected 0", o); end
        set_idle();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        pop_cmp("post_reset_sb");
    endtask

    initial begin
        set_idle();
        test_reset();
        test_normal();
        test_bypass();
        test_load_use();
        test_flush_hold();
        test_saturation();
        test_reset_mid_stall();
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
